// File: rtl/key_pio_debounced.sv
// Memory-mapped key/switch input port: two-flop synchroniser, per-channel debounce,
// selectable rise/fall edge capture with write-1-to-clear bits and a maskable level IRQ.
module key_pio_debounced #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] IDLE_VALUE      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]           sync1_q, sync2_q;
    logic [WIDTH-1:0]           stable_q, stable_d;
    logic [WIDTH-1:0]           stable_dly_q;
    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]           capture_q, capture_d;
    logic [WIDTH-1:0]           rise_en_q, rise_en_d;
    logic [WIDTH-1:0]           fall_en_q, fall_en_d;
    logic [WIDTH-1:0]           readdata_q, readdata_d;

    logic             wr;
    logic [WIDTH-1:0] rise, fall, ev, w1c;

    // A channel only accepts a new level after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign wr   = chipselect & ~write_n;
    assign rise = stable_q & ~stable_dly_q;
    assign fall = ~stable_q & stable_dly_q;
    assign ev   = (rise & rise_en_q) | (fall & fall_en_q);
    assign w1c  = (wr && address == 3'd3) ? writedata : '0;

    // A new event outranks a simultaneous clear so no edge is lost.
    assign capture_d  = ev | (capture_q & ~w1c);
    assign irq_mask_d = (wr && address == 3'd2) ? writedata : irq_mask_q;
    assign rise_en_d  = (wr && address == 3'd4) ? writedata : rise_en_q;
    assign fall_en_d  = (wr && address == 3'd5) ? writedata : fall_en_q;

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d = stable_q;
            3'd1:    readdata_d = sync2_q;
            3'd2:    readdata_d = irq_mask_q;
            3'd3:    readdata_d = capture_q;
            3'd4:    readdata_d = rise_en_q;
            3'd5:    readdata_d = fall_en_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q      <= IDLE_VALUE;
            sync2_q      <= IDLE_VALUE;
            stable_q     <= IDLE_VALUE;
            stable_dly_q <= IDLE_VALUE;
            cnt_q        <= '0;
            irq_mask_q   <= '0;
            capture_q    <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            readdata_q   <= '0;
        end else begin
            sync1_q      <= in_port;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            irq_mask_q   <= irq_mask_d;
            capture_q    <= capture_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            readdata_q   <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(capture_q & irq_mask_q);

endmodule

// File: tb/tb_key_pio_debounced.sv
// Randomised and directed bench for key_pio_debounced; a history-based reference model
// queues expected read data and a separate monitor compares readdata and irq.
module tb_key_pio_debounced;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [W-1:0] writedata;
    logic [W-1:0] in_port;
    logic [W-1:0] readdata;
    logic         irq;

    always #5 clk = ~clk;

    key_pio_debounced #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .IDLE_VALUE      (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 0;
    bit rd_req  = 0;
    logic [W-1:0] rd_q[$];

    // Reference state: pin samples, accepted levels and the software-visible registers.
    logic [W-1:0] m_s1 = '1, m_s2 = '1, m_st = '1, m_prev = '1;
    logic [W-1:0] m_mask = '0, m_cap = '0, m_rise = '0, m_fall = '0;
    logic [W-1:0] hist[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // A level is accepted once the last D synchronised samples all disagree with it.
    task automatic model_step();
        logic [W-1:0] ev, w1c, rd_exp, nst;
        bit wr, all_diff;
        if (!reset_n) begin
            m_s1 = '1; m_s2 = '1; m_st = '1; m_prev = '1;
            m_mask = '0; m_cap = '0; m_rise = '0; m_fall = '0;
            hist.delete();
            return;
        end
        wr = chipselect && !write_n;
        case (address)
            3'd0:    rd_exp = m_st;
            3'd1:    rd_exp = m_s2;
            3'd2:    rd_exp = m_mask;
            3'd3:    rd_exp = m_cap;
            3'd4:    rd_exp = m_rise;
            3'd5:    rd_exp = m_fall;
            default: rd_exp = '0;
        endcase
        if (rd_req) rd_q.push_back(rd_exp);
        ev  = (m_st & ~m_prev & m_rise) | (~m_st & m_prev & m_fall);
        w1c = (wr && address == 3'd3) ? writedata : '0;
        m_cap = ev | (m_cap & ~w1c);
        if (wr && address == 3'd2) m_mask = writedata;
        if (wr && address == 3'd4) m_rise = writedata;
        if (wr && address == 3'd5) m_fall = writedata;
        hist.push_back(m_s2);
        if (hist.size() > D) void'(hist.pop_front());
        nst = m_st;
        if (hist.size() == D) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1;
                foreach (hist[k]) if (hist[k][i] == m_st[i]) all_diff = 0;
                if (all_diff) nst[i] = ~m_st[i];
            end
        end
        m_prev = m_st;
        m_st   = nst;
        m_s2   = m_s1;
        m_s1   = in_port;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            while (rd_q.size() > 0) chk("readdata", 32'(readdata), 32'(rd_q.pop_front()));
            chk("irq", 32'(irq), 32'(|(m_cap & m_mask)));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a; rd_req = 1;
        @(negedge clk);
        rd_req = 0;
    endtask

    initial begin
        int budget;
        reset_n = 1'b0; in_port = 4'hF; address = '0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        idle(2);
        reset_n = 1'b1;
        started = 1;
        chk("reset_readdata", 32'(readdata), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        rd(3'd0);

        // Falling press captured, release ignored with RISE_EN clear.
        wr(3'd5, 4'h1); wr(3'd2, 4'h1);
        in_port = 4'hE; idle(8);
        rd(3'd0); rd(3'd3);
        in_port = 4'hF; idle(10);
        rd(3'd3); wr(3'd3, 4'hF);

        // Glitch shorter than the debounce window.
        in_port = 4'hD; idle(3);
        in_port = 4'hF; idle(8);
        rd(3'd0); rd(3'd3);

        // Two captured bits, selective write-1-to-clear.
        wr(3'd5, 4'h3);
        in_port = 4'hC; idle(8);
        in_port = 4'hF; idle(8);
        wr(3'd2, 4'h2); rd(3'd3);
        wr(3'd3, 4'h1); rd(3'd3);

        // Clear lands on the same edge as a new bit-0 event.
        wr(3'd3, 4'hF); wr(3'd2, 4'h1);
        in_port = 4'hE; idle(6);
        wr(3'd3, 4'h1); rd(3'd3);
        in_port = 4'hF; idle(8);
        rd(3'd3); wr(3'd3, 4'hF);

        // Reset while a change is still being debounced.
        in_port = 4'hB; idle(4);
        reset_n = 1'b0; in_port = 4'hF; idle(1);
        reset_n = 1'b1; idle(8);
        rd(3'd0); rd(3'd3);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rd(3'($urandom_range(0, 7)));
                4, 5, 6:    wr(3'($urandom_range(0, 7)), W'($urandom));
                7: begin
                    if ($urandom_range(0, 19) == 0) begin
                        reset_n = 1'b0; idle(1); reset_n = 1'b1;
                    end else idle(1);
                end
                default:    idle(1);
            endcase
        end

        budget = 10;
        while (rd_q.size() > 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        if (rd_q.size() > 0) chk("drain", 32'(rd_q.size()), 32'h0);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
